// File: rtl/blockram_arbiter_if.sv
// Request/response bundle between two read requesters, the arbiter and the
// blockram read port. The slave modport is the arbiter's view.
interface blockram_arbiter_if;
   logic        req0;
   logic        req1;
   logic [16:0] addr0;
   logic [16:0] addr1;
   logic [2:0]  len0;
   logic [2:0]  len1;
   logic        gnt0;
   logic        gnt1;
   logic        rvalid0;
   logic        rvalid1;
   logic        rlast0;
   logic        rlast1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;
   logic [16:0] ram_addr;
   logic [31:0] ram_data;

   modport slave (
      input  req0, req1, addr0, addr1, len0, len1, ram_data,
      output gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, rdata0, rdata1, ram_addr
   );

   modport master (
      output req0, req1, addr0, addr1, len0, len1, ram_data,
      input  gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, rdata0, rdata1, ram_addr
   );
endinterface

// File: rtl/blockram_arbiter.sv
// Two-port read arbiter and burst sequencer for the boot/ROM blockram.
// Bursts are expanded into one word read per cycle; data returns two cycles
// after the beat is issued, tagged with the owning port.
module blockram_arbiter (
   input  logic                 clk,
   input  logic                 rst,
   blockram_arbiter_if.slave    bus
);

   logic [2:0]  remaining_reg;
   logic [16:0] next_addr_reg;
   logic        owner_reg;
   logic        last_owner_reg;
   logic        v1_reg, id1_reg, last1_reg;
   logic        v2_reg, id2_reg, last2_reg;
   logic [31:0] rdata_reg;

   logic        free;
   logic        grant0;
   logic        grant1;
   logic        issue_next;
   logic        issue_id_next;
   logic        issue_last_next;
   logic [16:0] ram_addr_next;

   // Arbitration only while idle; on a tie the port that did not win last time wins.
   // Grants are suppressed while reset is held so the outputs stay quiet.
   assign free   = (remaining_reg == 3'd0);
   assign grant0 = !rst && free && bus.req0 && (!bus.req1 ||  last_owner_reg);
   assign grant1 = !rst && free && bus.req1 && (!bus.req0 || !last_owner_reg);

   // Select the beat issued this cycle: a freshly granted first beat or the next burst beat.
   always_comb begin
      issue_next      = 1'b0;
      issue_id_next   = owner_reg;
      issue_last_next = 1'b0;
      ram_addr_next   = 17'd0;
      if (grant0) begin
         issue_next      = 1'b1;
         issue_id_next   = 1'b0;
         issue_last_next = (bus.len0 == 3'd0);
         ram_addr_next   = bus.addr0;
      end else if (grant1) begin
         issue_next      = 1'b1;
         issue_id_next   = 1'b1;
         issue_last_next = (bus.len1 == 3'd0);
         ram_addr_next   = bus.addr1;
      end else if (!free) begin
         issue_next      = 1'b1;
         issue_id_next   = owner_reg;
         issue_last_next = (remaining_reg == 3'd1);
         ram_addr_next   = next_addr_reg;
      end
   end

   // Burst sequencer: load on grant, then count down while advancing the address (wraps mod 2^17).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining_reg  <= 3'd0;
         next_addr_reg  <= 17'd0;
         owner_reg      <= 1'b0;
         last_owner_reg <= 1'b1;
      end else if (grant0) begin
         remaining_reg  <= bus.len0;
         next_addr_reg  <= bus.addr0 + 17'd1;
         owner_reg      <= 1'b0;
         last_owner_reg <= 1'b0;
      end else if (grant1) begin
         remaining_reg  <= bus.len1;
         next_addr_reg  <= bus.addr1 + 17'd1;
         owner_reg      <= 1'b1;
         last_owner_reg <= 1'b1;
      end else if (!free) begin
         remaining_reg  <= remaining_reg - 3'd1;
         next_addr_reg  <= next_addr_reg + 17'd1;
      end
   end

   // Two-stage tag pipeline matching the blockram latency; reset drops in-flight beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_reg    <= 1'b0;
         id1_reg   <= 1'b0;
         last1_reg <= 1'b0;
         v2_reg    <= 1'b0;
         id2_reg   <= 1'b0;
         last2_reg <= 1'b0;
      end else begin
         v1_reg    <= issue_next;
         id1_reg   <= issue_id_next;
         last1_reg <= issue_last_next;
         v2_reg    <= v1_reg;
         id2_reg   <= id1_reg;
         last2_reg <= last1_reg;
      end
   end

   // Capture blockram output only for returning beats; otherwise hold the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_reg <= 32'd0;
      end else if (v1_reg) begin
         rdata_reg <= bus.ram_data;
      end
   end

   assign bus.gnt0     = grant0;
   assign bus.gnt1     = grant1;
   assign bus.ram_addr = ram_addr_next;
   assign bus.rvalid0  = v2_reg && !id2_reg;
   assign bus.rvalid1  = v2_reg &&  id2_reg;
   assign bus.rlast0   = v2_reg && !id2_reg && last2_reg;
   assign bus.rlast1   = v2_reg &&  id2_reg && last2_reg;
   assign bus.rdata0   = rdata_reg;
   assign bus.rdata1   = rdata_reg;

endmodule

// File: tb/tb_blockram_arbiter.sv
// Bench for blockram_arbiter: a beat-queue model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_blockram_arbiter;

   logic clk;
   logic rst;

   blockram_arbiter_if bus ();

   blockram_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Blockram contents: a fixed scramble of the address
   function automatic logic [31:0] mem_f(input logic [16:0] a);
      return (32'(a) * 32'h9E3779B1) ^ 32'hC0DE0000;
   endfunction

   always @(posedge clk) bus.ram_data <= mem_f(bus.ram_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- requester driver ----------------
   typedef struct { logic [16:0] addr; logic [2:0] len; } req_t;
   req_t q0[$];
   req_t q1[$];
   bit   seen0 = 0, seen1 = 0;

   initial begin
      bus.req0 = 0; bus.req1 = 0;
      bus.addr0 = 0; bus.addr1 = 0;
      bus.len0 = 0; bus.len1 = 0;
   end

   // Hold each queued request until its grant has been seen, then advance
   always @(posedge clk) begin
      #2;
      if (rst) begin
         q0.delete(); q1.delete();
         seen0 = 0; seen1 = 0;
      end else begin
         if (seen0 && q0.size() > 0) q0.delete(0);
         if (seen1 && q1.size() > 0) q1.delete(0);
         seen0 = 0; seen1 = 0;
      end
      if (q0.size() > 0) begin bus.req0 = 1; bus.addr0 = q0[0].addr; bus.len0 = q0[0].len; end
      else               begin bus.req0 = 0; bus.addr0 = 0;          bus.len0 = 0;         end
      if (q1.size() > 0) begin bus.req1 = 1; bus.addr1 = q1[0].addr; bus.len1 = q1[0].len; end
      else               begin bus.req1 = 0; bus.addr1 = 0;          bus.len1 = 0;         end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   typedef struct { logic [16:0] addr; bit port; bit last; int due; } beat_t;
   beat_t       issue_q[$];
   beat_t       ret_q[$];
   bit          m_last_owner = 1;
   logic [31:0] m_rdata = 0;

   always @(negedge clk) begin
      logic        eg0, eg1, erv0, erv1, erl0, erl1;
      logic [16:0] eaddr;
      beat_t       b;
      eg0 = 0; eg1 = 0; erv0 = 0; erv1 = 0; erl0 = 0; erl1 = 0; eaddr = 0;
      if (rst) begin
         issue_q.delete(); ret_q.delete();
         m_last_owner = 1;
         m_rdata = 0;
      end else begin
         if (issue_q.size() == 0) begin
            if (bus.req0 && (!bus.req1 || m_last_owner)) eg0 = 1;
            else if (bus.req1) eg1 = 1;
         end
         if (eg0 || eg1) begin
            logic [16:0] a;
            int          n;
            a = eg0 ? bus.addr0 : bus.addr1;
            n = eg0 ? int'(bus.len0) : int'(bus.len1);
            for (int i = 0; i <= n; i++) begin
               b.addr = a + 17'(i);
               b.port = eg1;
               b.last = (i == n);
               b.due  = 0;
               issue_q.push_back(b);
            end
            m_last_owner = eg1;
         end
         if (issue_q.size() > 0) begin
            b = issue_q.pop_front();
            eaddr = b.addr;
            b.due = cyc + 2;
            ret_q.push_back(b);
         end
         if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            b = ret_q.pop_front();
            if (b.port) begin erv1 = 1; erl1 = b.last; end
            else        begin erv0 = 1; erl0 = b.last; end
            m_rdata = mem_f(b.addr);
         end
         if (bus.gnt0) seen0 = 1;
         if (bus.gnt1) seen1 = 1;
      end
      chk("m_gnt0",     32'(bus.gnt0),     32'(eg0));
      chk("m_gnt1",     32'(bus.gnt1),     32'(eg1));
      chk("m_ram_addr", 32'(bus.ram_addr), 32'(eaddr));
      chk("m_rvalid0",  32'(bus.rvalid0),  32'(erv0));
      chk("m_rvalid1",  32'(bus.rvalid1),  32'(erv1));
      chk("m_rlast0",   32'(bus.rlast0),   32'(erl0));
      chk("m_rlast1",   32'(bus.rlast1),   32'(erl1));
      if (erv0 || erv1 || rst) begin
         chk("m_rdata0", bus.rdata0, m_rdata);
         chk("m_rdata1", bus.rdata1, m_rdata);
      end else begin
         chk("m_rdata_hold0", bus.rdata0, m_rdata);
      end
      cyc++;
   end

   // ---------------- directed vectors ----------------
   task automatic start_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit p, input logic [16:0] a, input logic [2:0] l);
      req_t r;
      r.addr = a;
      r.len  = l;
      if (p) q1.push_back(r);
      else   q0.push_back(r);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1;
      @(negedge clk);
      chk("rst_gnt0",     32'(bus.gnt0),     32'd0);
      chk("rst_rvalid0",  32'(bus.rvalid0),  32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_rdata",    bus.rdata0,        32'd0);
      @(posedge clk); @(posedge clk);
      #1;
      // Tie out of reset, len = 1 each
      rst = 0;
      push(0, 17'h00040, 3'd1);
      push(1, 17'h00080, 3'd1);
      @(negedge clk);                                   // cycle 0
      chk("tie_gnt0_c0", 32'(bus.gnt0), 32'd1);
      chk("tie_gnt1_c0", 32'(bus.gnt1), 32'd0);
      chk("tie_addr_c0", 32'(bus.ram_addr), 32'h00040);
      idle(2);                                          // cycle 2
      chk("tie_gnt1_c2", 32'(bus.gnt1), 32'd1);
      chk("tie_addr_c2", 32'(bus.ram_addr), 32'h00080);
      chk("tie_rv0_c2",  32'(bus.rvalid0), 32'd1);
      idle(1);                                          // cycle 3
      start_cycle();                                    // cycle 4: re-raise both
      push(0, 17'h00050, 3'd0);
      push(1, 17'h00090, 3'd0);
      @(negedge clk);
      chk("tie2_gnt0", 32'(bus.gnt0), 32'd1);
      chk("tie2_gnt1", 32'(bus.gnt1), 32'd0);
      idle(6);

      // Single read
      start_cycle();
      push(0, 17'h00010, 3'd0);
      @(negedge clk);                                   // cycle 0
      chk("single_gnt0", 32'(bus.gnt0), 32'd1);
      chk("single_addr", 32'(bus.ram_addr), 32'h00010);
      idle(2);                                          // cycle 2
      chk("single_rv0",   32'(bus.rvalid0), 32'd1);
      chk("single_rl0",   32'(bus.rlast0),  32'd1);
      chk("single_rdata", bus.rdata0, mem_f(17'h00010));
      idle(1);                                          // cycle 3
      chk("single_done",  32'(bus.rvalid0), 32'd0);
      idle(4);

      // Burst wrap on port 1
      start_cycle();
      push(1, 17'h1FFFE, 3'd3);
      @(negedge clk);
      chk("wrap_addr0", 32'(bus.ram_addr), 32'h1FFFE);
      chk("wrap_gnt1",  32'(bus.gnt1), 32'd1);
      @(negedge clk);
      chk("wrap_addr1", 32'(bus.ram_addr), 32'h1FFFF);
      chk("wrap_nognt", 32'(bus.gnt1), 32'd0);
      @(negedge clk);
      chk("wrap_addr2", 32'(bus.ram_addr), 32'h00000);
      chk("wrap_rv_c2", 32'(bus.rvalid1), 32'd1);
      @(negedge clk);
      chk("wrap_addr3", 32'(bus.ram_addr), 32'h00001);
      @(negedge clk);                                   // cycle 4
      chk("wrap_data4", bus.rdata1, mem_f(17'h00000));
      chk("wrap_rl_c4", 32'(bus.rlast1), 32'd0);
      @(negedge clk);                                   // cycle 5
      chk("wrap_rl_c5", 32'(bus.rlast1), 32'd1);
      chk("wrap_data5", bus.rdata1, mem_f(17'h00001));
      idle(4);

      // Streaming single-word requests
      start_cycle();
      for (int i = 0; i < 8; i++) push(0, 17'h00100 + 17'(i), 3'd0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c < 8) chk("stream_gnt0", 32'(bus.gnt0), 32'd1);
         if (c >= 2) begin
            chk("stream_rv0",   32'(bus.rvalid0), 32'd1);
            chk("stream_rdata", bus.rdata0, mem_f(17'h00100 + 17'(c - 2)));
         end
      end
      idle(4);

      // Contention mid-burst
      start_cycle();
      push(0, 17'h00200, 3'd7);
      @(negedge clk);                                   // cycle 0
      start_cycle();                                    // cycle 1
      push(1, 17'h00300, 3'd1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c < 8)  chk("cont_nognt1", 32'(bus.gnt1), 32'd0);
         if (c == 8) chk("cont_gnt1",   32'(bus.gnt1), 32'd1);
         if (c == 9) chk("cont_rlast0", 32'(bus.rlast0), 32'd1);
         if (c == 10) begin
            chk("cont_rv1",    32'(bus.rvalid1), 32'd1);
            chk("cont_rdata1", bus.rdata1, mem_f(17'h00300));
         end
         if (c < 10) start_cycle();
      end
      idle(4);

      // Reset abort in cycle 3 of an 8-beat burst
      start_cycle();
      push(0, 17'h00400, 3'd7);
      idle(3);                                          // cycles 0-2
      start_cycle();                                    // cycle 3
      rst = 1;
      @(negedge clk);
      chk("abort_rv0",  32'(bus.rvalid0),  32'd0);
      chk("abort_addr", 32'(bus.ram_addr), 32'd0);
      chk("abort_rd",   bus.rdata0,        32'd0);
      start_cycle();
      start_cycle();
      rst = 0;
      push(1, 17'h00500, 3'd0);
      @(negedge clk);
      chk("abort_gnt1", 32'(bus.gnt1), 32'd1);
      chk("abort_rv_after", 32'(bus.rvalid0), 32'd0);
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $fatal(1);
   end

endmodule
